// File: rtl/lms_coef_update.sv
// -----------------------------------------------------------------------------
// lms_coef_update
//
// Sign-preserving LMS coefficient adaptation for an N_COEF-tap feed-forward
// equalizer. Each tap keeps a wide signed accumulator. On every enabled sample
// the accumulator moves against the product of the slicer error and the data
// sample that produced it. The product is scaled by a power-of-two step that is
// coarse during acquisition and fine during tracking. The visible coefficient
// is the top COEF_BW bits of the accumulator (7 fraction bits, 1.0 = 128).
//
// The error arrives ERR_DLY enabled samples after its data, so the update for
// tap k pairs i_err with dl[ERR_DLY-1+k].
//
// Ports
//   i_clk     clock; all state updates on the rising edge
//   i_rst     synchronous active-high reset (highest priority)
//   i_en      sample strobe; shifts the delay line and permits an update
//   i_data    signed equalizer input sample (DATA_BW)
//   i_err     signed slicer error, FFE output minus decision (ERR_BW)
//   i_start   leave IDLE and begin acquisition
//   i_freeze  hold coefficients and the update counter (no effect in IDLE)
//   i_clear   reload initial coefficients, clear o_sat, return to IDLE
//   o_coefs   packed taps; tap k at [COEF_BW*(k+1)-1 : COEF_BW*k]
//   o_state   IDLE=0, ACQ=1, TRK=2
//   o_sat     sticky flag: some accumulator was clamped
// -----------------------------------------------------------------------------
module lms_coef_update #(
  parameter int DATA_BW  = 11,
  parameter int ERR_BW   = 11,
  parameter int COEF_BW  = 9,
  parameter int N_COEF   = 7,
  parameter int FRAC_EXT = 12,
  parameter int CENTER   = 3,
  parameter int ERR_DLY  = 2,
  parameter int MU_ACQ   = 8,
  parameter int MU_TRK   = 12,
  parameter int ACQ_LEN  = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [DATA_BW-1:0]         i_data,
  input  logic [ERR_BW-1:0]          i_err,
  input  logic                       i_start,
  input  logic                       i_freeze,
  input  logic                       i_clear,
  output logic [COEF_BW*N_COEF-1:0]  o_coefs,
  output logic [1:0]                 o_state,
  output logic                       o_sat
);

  localparam int ACC_BW  = COEF_BW + FRAC_EXT;
  localparam int PROD_BW = DATA_BW + ERR_BW;
  // One bit above the wider operand so acc - t never wraps before clamping.
  localparam int SUM_BW  = ((ACC_BW > PROD_BW) ? ACC_BW : PROD_BW) + 1;
  localparam int DL_LEN  = N_COEF + ERR_DLY - 1;

  localparam logic signed [ACC_BW-1:0] ACC_ONE = ACC_BW'(longint'(128) << FRAC_EXT);
  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};
  localparam logic [15:0]              CNT_LAST = 16'(ACQ_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_TRK  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [15:0]                cnt_q, cnt_d;
  logic                       sat_q, sat_d;
  logic signed [DATA_BW-1:0]  dl_q  [DL_LEN];
  logic signed [DATA_BW-1:0]  dl_d  [DL_LEN];
  logic signed [ACC_BW-1:0]   acc_q [N_COEF];
  logic signed [ACC_BW-1:0]   acc_d [N_COEF];

  logic signed [PROD_BW-1:0]  prod  [N_COEF];
  logic signed [PROD_BW-1:0]  term  [N_COEF];
  logic signed [SUM_BW-1:0]   diff  [N_COEF];
  logic [7:0]                 mu_sel;
  logic                       do_upd;

  // Per-tap datapath: full-precision product, floor shift, widened difference.
  // dl_q is the pre-shift content, which is what pairs with this edge's error.
  always_comb begin
    mu_sel = (state_q == ST_TRK) ? 8'(MU_TRK) : 8'(MU_ACQ);
    for (int k = 0; k < N_COEF; k++) begin
      prod[k] = $signed(i_err) * dl_q[ERR_DLY-1+k];
      term[k] = prod[k] >>> mu_sel;
      diff[k] = SUM_BW'(acc_q[k]) - SUM_BW'(term[k]);
    end
  end

  assign do_upd = i_en && !i_freeze && !i_clear &&
                  ((state_q == ST_ACQ) || (state_q == ST_TRK));

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through this
    // block leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    dl_d    = dl_q;
    acc_d   = acc_q;

    // The delay line follows the sample stream in every state.
    if (i_en) begin
      dl_d[0] = $signed(i_data);
      for (int j = 1; j < DL_LEN; j++) dl_d[j] = dl_q[j-1];
    end

    if (do_upd) begin
      for (int k = 0; k < N_COEF; k++) begin
        // In range exactly when the bits from the ACC sign bit upward agree.
        if (diff[k][SUM_BW-1:ACC_BW-1] == {(SUM_BW-ACC_BW+1){diff[k][SUM_BW-1]}}) begin
          acc_d[k] = diff[k][ACC_BW-1:0];
        end else begin
          acc_d[k] = diff[k][SUM_BW-1] ? ACC_MIN : ACC_MAX;
          sat_d    = 1'b1;
        end
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ACQ;
          cnt_d   = '0;
        end
      end
      ST_ACQ: begin
        if (do_upd) begin
          cnt_d = cnt_q + 16'd1;
          // The ACQ_LEN-th update itself still uses MU_ACQ (mu_sel follows state_q).
          if (cnt_q == CNT_LAST) state_d = ST_TRK;
        end
      end
      ST_TRK:  state_d = ST_TRK;
      default: state_d = ST_IDLE;
    endcase

    if (i_clear) begin
      for (int k = 0; k < N_COEF; k++) acc_d[k] = (k == CENTER) ? ACC_ONE : '0;
      state_d = ST_IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      // NOTE: the delay line and accumulators are register arrays, not RAM;
      // resetting them guarantees that no adaptation survives a reset.
      for (int j = 0; j < DL_LEN; j++) dl_q[j] <= '0;
      for (int k = 0; k < N_COEF; k++) acc_q[k] <= (k == CENTER) ? ACC_ONE : '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      dl_q    <= dl_d;
      acc_q   <= acc_d;
    end
  end

  for (genvar k = 0; k < N_COEF; k++) begin : g_tap
    assign o_coefs[COEF_BW*k +: COEF_BW] = acc_q[k][ACC_BW-1:FRAC_EXT];
  end

  assign o_state = state_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_lms_coef_update.sv
// -----------------------------------------------------------------------------
// tb_lms_coef_update
//
// Three instances share one stimulus stream:
//   dut0  default parameters (table-driven vectors)
//   dut1  ACQ_LEN=4          (acquisition-to-tracking handover, freeze)
//   dut2  MU_ACQ=0           (accumulator saturation and clear)
// Expected coefficients are hand-computed; each vector applies its inputs for
// `reps` clock edges and then compares the outputs 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_lms_coef_update;

  logic        clk = 1'b0;
  logic        rst, en, start, freeze, clr;
  logic [10:0] data, err;

  logic [62:0] coefs0, coefs1, coefs2;
  logic [1:0]  state0, state1, state2;
  logic        sat0, sat1, sat2;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  lms_coef_update dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_err(err),
    .i_start(start), .i_freeze(freeze), .i_clear(clr),
    .o_coefs(coefs0), .o_state(state0), .o_sat(sat0)
  );

  lms_coef_update #(.ACQ_LEN(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_err(err),
    .i_start(start), .i_freeze(freeze), .i_clear(clr),
    .o_coefs(coefs1), .o_state(state1), .o_sat(sat1)
  );

  lms_coef_update #(.MU_ACQ(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_err(err),
    .i_start(start), .i_freeze(freeze), .i_clear(clr),
    .o_coefs(coefs2), .o_state(state2), .o_sat(sat2)
  );

  typedef struct {
    string    name;
    logic     rst, en, start, freeze, clr;
    int       data, err;
    int       reps;
    int       exp_c, exp_o;
    logic [1:0] exp_st;
    logic     exp_sat;
  } vec_t;

  // Expected bus: tap 3 holds `c`, every other tap holds `o` (9-bit two's complement).
  function automatic logic [62:0] mk_bus(input int c, input int o);
    logic [62:0] b;
    b = '0;
    for (int k = 0; k < 7; k++) b[9*k +: 9] = (k == 3) ? 9'(c) : 9'(o);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic f,
                       input logic c, input int d, input int er);
    rst = r; en = e; start = s; freeze = f; clr = c;
    data = 11'(d); err = 11'(er);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    //            name              rst en  st  frz clr data   err  reps  c    o   st  sat
    vecs[0] = '{"reset",           1, 0, 0, 0, 0,    0,    0,   1, 128,  0, 0, 0};
    vecs[1] = '{"idle_no_update",  0, 1, 0, 0, 0,   50,  100,  20, 128,  0, 0, 0};
    vecs[2] = '{"idle_fill",       0, 1, 0, 0, 0,  100,    0,   8, 128,  0, 0, 0};
    vecs[3] = '{"start",           0, 0, 1, 0, 0,    0,    0,   1, 128,  0, 1, 0};
    // t = 256*100 >>> 8 = 100: center 524188 -> 127, others -100 -> -1
    vecs[4] = '{"acq_update",      0, 1, 0, 0, 0,  100,  256,   1, 127, -1, 1, 0};
    vecs[5] = '{"freeze_hold",     0, 1, 0, 1, 0, 1023,  200,  10, 127, -1, 1, 0};
    // dl now all 1023: t = 1046529 >>> 8 = 4088 -> center 520100 (126), others -4188 (-2)
    vecs[6] = '{"freeze_release",  0, 1, 0, 0, 0,    0, 1023,   1, 126, -2, 1, 0};
    vecs[7] = '{"clear_priority",  0, 1, 1, 0, 1,    0, 1023,   1, 128,  0, 0, 0};
    vecs[8] = '{"restart",         0, 0, 1, 0, 0,    0,    0,   1, 128,  0, 1, 0};
    vecs[9] = '{"reset_mid_acq",   1, 1, 0, 0, 0, 1023, 1023,   1, 128,  0, 0, 0};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].start, vecs[i].freeze, vecs[i].clr,
            vecs[i].data, vecs[i].err);
      cycles(vecs[i].reps);
      check({vecs[i].name, "_coefs"}, 64'(coefs0), 64'(mk_bus(vecs[i].exp_c, vecs[i].exp_o)));
      check({vecs[i].name, "_state"}, 64'(state0), 64'(vecs[i].exp_st));
      check({vecs[i].name, "_sat"},   64'(sat0),   64'(vecs[i].exp_sat));
    end

    // ---- dut1: ACQ_LEN=4 handover, freeze does not count ----
    drive(1, 0, 0, 0, 0, 0, 0);       cycles(1);
    drive(0, 1, 0, 0, 0, 1023, 0);    cycles(8);
    drive(0, 0, 1, 0, 0, 1023, 0);    cycles(1);
    check("acq4_start_state", 64'(state1), 64'd1);
    drive(0, 1, 0, 0, 0, 1023, 0);    cycles(2);
    check("acq4_upd2_state", 64'(state1), 64'd1);
    drive(0, 1, 0, 1, 0, 1023, 200);  cycles(10);
    check("acq4_freeze_state", 64'(state1), 64'd1);
    check("acq4_freeze_coefs", 64'(coefs1), 64'(mk_bus(128, 0)));
    drive(0, 1, 0, 0, 0, 1023, 0);    cycles(1);
    check("acq4_upd3_state", 64'(state1), 64'd1);
    // 4th update still MU_ACQ: t = floor(-1046529/256) = -4089 -> center 528377 (128), others 4089 (0)
    drive(0, 1, 0, 0, 0, 1023, -1023); cycles(1);
    check("acq4_upd4_state", 64'(state1), 64'd2);
    check("acq4_upd4_coefs", 64'(coefs1), 64'(mk_bus(128, 0)));
    // 5th update MU_TRK: t = floor(-1046529/4096) = -256 -> center 528633 (129), others 4345 (1)
    cycles(1);
    check("trk_upd5_coefs", 64'(coefs1), 64'(mk_bus(129, 1)));
    drive(0, 1, 1, 0, 0, 1023, -1023); cycles(1);
    check("trk_start_ignored", 64'(state1), 64'd2);
    check("trk_upd6_coefs", 64'(coefs1), 64'(mk_bus(129, 1)));

    // ---- dut2: MU_ACQ=0 saturation ----
    drive(1, 0, 0, 0, 0, 0, 0);       cycles(1);
    drive(0, 1, 0, 0, 0, 1023, 0);    cycles(8);
    drive(0, 0, 1, 0, 0, 1023, 0);    cycles(1);
    // center 524288+1046529 clamps to 2^20-1; others 1046529 -> 255
    drive(0, 1, 0, 0, 0, 1023, -1023); cycles(1);
    check("sat_upd1_coefs", 64'(coefs2), 64'(mk_bus(255, 255)));
    check("sat_upd1_flag",  64'(sat2),   64'd1);
    cycles(1);
    check("sat_upd2_coefs", 64'(coefs2), 64'(mk_bus(255, 255)));
    drive(0, 1, 0, 0, 0, 1023, 0);    cycles(3);
    check("sat_sticky", 64'(sat2), 64'd1);
    check("sat_state",  64'(state2), 64'd1);
    drive(0, 1, 0, 0, 1, 1023, -1023); cycles(1);
    check("clear_sat",   64'(sat2),   64'd0);
    check("clear_coefs", 64'(coefs2), 64'(mk_bus(128, 0)));
    check("clear_state", 64'(state2), 64'd0);

    drive(0, 0, 0, 0, 0, 0, 0);
    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
